// File: rtl/uart_frame_receiver.sv
// 8N-even-1 UART receiver with 16x oversampling, 3-sample majority voting and
// per-frame valid / parity-error / framing-error status.
module uart_frame_receiver (
  input  logic       give_clk,
  input  logic       give_reset,
  input  logic [2:0] baud_select,
  input  logic       RX_EN,
  input  logic       RxD,
  output logic [7:0] Rx_DATA,
  output logic       Rx_VALID,
  output logic       Rx_PERROR,
  output logic       Rx_FERROR
);

  localparam int unsigned DIV_W  = 14;
  localparam int unsigned S_W    = 4;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned DATA_W = 8;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t             state, state_n;
  logic [1:0]         sync_q;
  logic               rxd_s, rxd_prev;
  logic [DIV_W-1:0]   div_q, div_n, reload;
  logic [S_W-1:0]     s_q, s_n, s_inc;
  logic [IDX_W-1:0]   idx_q, idx_n;
  logic [DATA_W-1:0]  shreg_q, shreg_n, data_n;
  logic               par_q, par_n, v7_q, v7_n, v8_q, v8_n;
  logic               valid_n, perr_n, ferr_n;
  logic               tick, vote, fall;

  // Divider reload value (N-1) per baud rate selection
  always_comb begin
    case (baud_select)
      3'd0:    reload = DIV_W'(10416);
      3'd1:    reload = DIV_W'(2603);
      3'd2:    reload = DIV_W'(650);
      3'd3:    reload = DIV_W'(325);
      3'd4:    reload = DIV_W'(162);
      3'd5:    reload = DIV_W'(80);
      3'd6:    reload = DIV_W'(53);
      default: reload = DIV_W'(26);
    endcase
  end

  assign rxd_s = sync_q[1];
  assign tick  = (div_q == '0);
  assign s_inc = s_q + S_W'(1);
  assign fall  = rxd_prev & ~rxd_s;
  assign vote  = (v7_q & v8_q) | (v7_q & rxd_s) | (v8_q & rxd_s);

  always_ff @(posedge give_clk or negedge give_reset) begin
    if (!give_reset) begin
      sync_q    <= 2'b11;
      rxd_prev  <= 1'b1;
      div_q     <= reload;
      s_q       <= '0;
      idx_q     <= '0;
      shreg_q   <= '0;
      par_q     <= 1'b0;
      v7_q      <= 1'b0;
      v8_q      <= 1'b0;
      state     <= IDLE;
      Rx_DATA   <= '0;
      Rx_VALID  <= 1'b0;
      Rx_PERROR <= 1'b0;
      Rx_FERROR <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], RxD};
      rxd_prev  <= rxd_s;
      div_q     <= div_n;
      s_q       <= s_n;
      idx_q     <= idx_n;
      shreg_q   <= shreg_n;
      par_q     <= par_n;
      v7_q      <= v7_n;
      v8_q      <= v8_n;
      state     <= state_n;
      Rx_DATA   <= data_n;
      Rx_VALID  <= valid_n;
      Rx_PERROR <= perr_n;
      Rx_FERROR <= ferr_n;
    end
  end

  // s_inc is the sample index reached on this tick: 9 decides a bit, 0 ends it
  always_comb begin
    state_n = state;
    div_n   = tick ? reload : div_q - DIV_W'(1);
    s_n     = s_q;
    idx_n   = idx_q;
    shreg_n = shreg_q;
    par_n   = par_q;
    v7_n    = v7_q;
    v8_n    = v8_q;
    data_n  = Rx_DATA;
    valid_n = Rx_VALID;
    perr_n  = Rx_PERROR;
    ferr_n  = Rx_FERROR;

    if (state != IDLE && tick) begin
      s_n = s_inc;
      if (s_inc == S_W'(7)) v7_n = rxd_s;
      if (s_inc == S_W'(8)) v8_n = rxd_s;
    end

    case (state)
      IDLE: begin
        if (RX_EN && fall) begin
          state_n = START;
          s_n     = '0;
          div_n   = reload;
        end
      end
      START: begin
        if (tick) begin
          if (s_inc == S_W'(9)) begin
            if (vote) begin
              state_n = IDLE;
            end else begin
              valid_n = 1'b0;
              perr_n  = 1'b0;
              ferr_n  = 1'b0;
            end
          end else if (s_inc == '0) begin
            state_n = DATA;
            idx_n   = '0;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (s_inc == S_W'(9)) begin
            shreg_n[idx_q] = vote;
          end else if (s_inc == '0) begin
            idx_n = idx_q + IDX_W'(1);
            if (idx_q == IDX_W'(7)) state_n = PARITY;
          end
        end
      end
      PARITY: begin
        if (tick) begin
          if (s_inc == S_W'(9)) par_n = vote;
          else if (s_inc == '0) state_n = STOP;
        end
      end
      STOP: begin
        // Publish at the stop-bit decision so back-to-back frames are caught
        if (tick && s_inc == S_W'(9)) begin
          data_n  = shreg_q;
          perr_n  = (^shreg_q) != par_q;
          ferr_n  = ~vote;
          valid_n = ((^shreg_q) == par_q) && vote;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    if (!RX_EN) begin
      state_n = IDLE;
      valid_n = 1'b0;
      perr_n  = 1'b0;
      ferr_n  = 1'b0;
    end
  end

endmodule
